// File: rtl/mem_req_pkg.sv
// Shared dcache request definitions: field widths, request bundle and command codes.
package mem_req_pkg;

    localparam int ADDR_W = 40;
    localparam int TAG_W  = 10;
    localparam int CMD_W  = 5;
    localparam int TYP_W  = 3;
    localparam int DATA_W = 64;
    localparam int REQ_W  = ADDR_W + TAG_W + CMD_W + TYP_W + 1 + 1 + DATA_W;

    // Memory command encodings used by the arbiter and the dcache.
    localparam logic [CMD_W-1:0] M_XRD       = 5'b00000;
    localparam logic [CMD_W-1:0] M_XWR       = 5'b00001;
    localparam logic [CMD_W-1:0] M_PFR       = 5'b00010;
    localparam logic [CMD_W-1:0] M_PFW       = 5'b00011;
    localparam logic [CMD_W-1:0] M_XA_SWAP   = 5'b00100;
    localparam logic [CMD_W-1:0] M_FLUSH_ALL = 5'b00101;
    localparam logic [CMD_W-1:0] M_XLR       = 5'b00110;
    localparam logic [CMD_W-1:0] M_XSC       = 5'b00111;
    localparam logic [CMD_W-1:0] M_XA_ADD    = 5'b01000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [CMD_W-1:0]  cmd;
        logic [TYP_W-1:0]  typ;
        logic              kill;
        logic              phys;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_req_ptr.sv
// Wrapping index register: advances by one per increment, DEPTH-1 wraps to 0.
module mem_req_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next index: clear wins over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Index register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_req_queue.sv
// Registered FIFO between the request arbiter and the dcache request port.
// Handshake outputs depend only on the occupancy register, so there is no
// combinational path enq->deq or deq_ready->enq_ready.
module mem_req_queue
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              io_enq_ready,
    input  logic              io_enq_valid,
    input  logic [ADDR_W-1:0] io_enq_bits_addr,
    input  logic [TAG_W-1:0]  io_enq_bits_tag,
    input  logic [CMD_W-1:0]  io_enq_bits_cmd,
    input  logic [TYP_W-1:0]  io_enq_bits_typ,
    input  logic              io_enq_bits_kill,
    input  logic              io_enq_bits_phys,
    input  logic [DATA_W-1:0] io_enq_bits_data,
    input  logic              io_deq_ready,
    output logic              io_deq_valid,
    output logic [ADDR_W-1:0] io_deq_bits_addr,
    output logic [TAG_W-1:0]  io_deq_bits_tag,
    output logic [CMD_W-1:0]  io_deq_bits_cmd,
    output logic [TYP_W-1:0]  io_deq_bits_typ,
    output logic              io_deq_bits_kill,
    output logic              io_deq_bits_phys,
    output logic [DATA_W-1:0] io_deq_bits_data,
    input  logic              io_flush,
    output logic [CNT_W-1:0]  io_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_req_t         storage_q [DEPTH];
    mem_req_t         enq_req;
    mem_req_t         deq_req;
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             enq_fire;
    logic             deq_fire;

    assign io_enq_ready = (count_q != CNT_W'(DEPTH));
    assign io_deq_valid = (count_q != '0);
    assign enq_fire     = io_enq_valid & io_enq_ready;
    assign deq_fire     = io_deq_valid & io_deq_ready;
    assign io_count     = count_q;

    assign enq_req = '{addr: io_enq_bits_addr, tag: io_enq_bits_tag, cmd: io_enq_bits_cmd,
                       typ: io_enq_bits_typ, kill: io_enq_bits_kill, phys: io_enq_bits_phys,
                       data: io_enq_bits_data};

    mem_req_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_enq_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (enq_fire),
        .ptr_o (enq_ptr)
    );

    mem_req_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_deq_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (deq_fire),
        .ptr_o (deq_ptr)
    );

    // Occupancy: flush empties; simultaneous enq and deq leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (io_flush) begin
            count_d = '0;
        end else if (enq_fire && !deq_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq_fire && !enq_fire) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage is data only and is left unreset; a flushed request is not written.
    always_ff @(posedge clk) begin
        if (enq_fire && !io_flush) begin
            storage_q[enq_ptr] <= enq_req;
        end
    end

    assign deq_req          = storage_q[deq_ptr];
    assign io_deq_bits_addr = deq_req.addr;
    assign io_deq_bits_tag  = deq_req.tag;
    assign io_deq_bits_cmd  = deq_req.cmd;
    assign io_deq_bits_typ  = deq_req.typ;
    assign io_deq_bits_kill = deq_req.kill;
    assign io_deq_bits_phys = deq_req.phys;
    assign io_deq_bits_data = deq_req.data;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a DEPTH=2 and a DEPTH=3 instance, each
// checked against an occupancy model and a FIFO scoreboard of expected requests.
module tb_mem_req_queue;
    import mem_req_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic     a_enq_valid, a_deq_ready, a_flush, a_enq_ready, a_deq_valid;
    mem_req_t a_enq, a_deq;
    logic [1:0] a_count;
    logic     b_enq_valid, b_deq_ready, b_flush, b_enq_ready, b_deq_valid;
    mem_req_t b_enq, b_deq;
    logic [1:0] b_count;

    mem_req_queue #(.DEPTH(2)) dut_a (
        .clk(clk), .reset(reset),
        .io_enq_ready(a_enq_ready), .io_enq_valid(a_enq_valid),
        .io_enq_bits_addr(a_enq.addr), .io_enq_bits_tag(a_enq.tag), .io_enq_bits_cmd(a_enq.cmd),
        .io_enq_bits_typ(a_enq.typ), .io_enq_bits_kill(a_enq.kill), .io_enq_bits_phys(a_enq.phys),
        .io_enq_bits_data(a_enq.data),
        .io_deq_ready(a_deq_ready), .io_deq_valid(a_deq_valid),
        .io_deq_bits_addr(a_deq.addr), .io_deq_bits_tag(a_deq.tag), .io_deq_bits_cmd(a_deq.cmd),
        .io_deq_bits_typ(a_deq.typ), .io_deq_bits_kill(a_deq.kill), .io_deq_bits_phys(a_deq.phys),
        .io_deq_bits_data(a_deq.data),
        .io_flush(a_flush), .io_count(a_count)
    );

    mem_req_queue #(.DEPTH(3)) dut_b (
        .clk(clk), .reset(reset),
        .io_enq_ready(b_enq_ready), .io_enq_valid(b_enq_valid),
        .io_enq_bits_addr(b_enq.addr), .io_enq_bits_tag(b_enq.tag), .io_enq_bits_cmd(b_enq.cmd),
        .io_enq_bits_typ(b_enq.typ), .io_enq_bits_kill(b_enq.kill), .io_enq_bits_phys(b_enq.phys),
        .io_enq_bits_data(b_enq.data),
        .io_deq_ready(b_deq_ready), .io_deq_valid(b_deq_valid),
        .io_deq_bits_addr(b_deq.addr), .io_deq_bits_tag(b_deq.tag), .io_deq_bits_cmd(b_deq.cmd),
        .io_deq_bits_typ(b_deq.typ), .io_deq_bits_kill(b_deq.kill), .io_deq_bits_phys(b_deq.phys),
        .io_deq_bits_data(b_deq.data),
        .io_flush(b_flush), .io_count(b_count)
    );

    int checks   = 0;
    int failures = 0;
    int mc_a = 0;
    int mc_b = 0;
    mem_req_t qa[$];
    mem_req_t qb[$];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic mem_req_t mk(input logic [9:0] tag);
        mem_req_t r;
        logic [63:0] rnd;
        rnd    = {$urandom, $urandom};
        r.addr = rnd[39:0];
        r.tag  = tag;
        r.cmd  = 5'($urandom_range(0, 8));
        r.typ  = 3'($urandom_range(0, 7));
        r.kill = 1'($urandom_range(0, 1));
        r.phys = 1'($urandom_range(0, 1));
        r.data = {$urandom, $urandom};
        return r;
    endfunction

    // One clock of the selected instance: check outputs against the model,
    // predict the handshakes, advance one edge, then update the model.
    task automatic tick(input int sel, output logic enq_fired);
        logic rdy, vld, ev, dr, fl, ef, df;
        logic [1:0] cnt;
        mem_req_t head, inb;
        int dep, mc;
        if (sel == 0) begin
            rdy = a_enq_ready; vld = a_deq_valid; cnt = a_count; head = a_deq;
            ev = a_enq_valid; dr = a_deq_ready; fl = a_flush; inb = a_enq; dep = 2; mc = mc_a;
        end else begin
            rdy = b_enq_ready; vld = b_deq_valid; cnt = b_count; head = b_deq;
            ev = b_enq_valid; dr = b_deq_ready; fl = b_flush; inb = b_enq; dep = 3; mc = mc_b;
        end
        chk(sel == 0 ? "a_enq_ready" : "b_enq_ready", 128'(rdy), 128'(mc != dep));
        chk(sel == 0 ? "a_deq_valid" : "b_deq_valid", 128'(vld), 128'(mc != 0));
        chk(sel == 0 ? "a_count" : "b_count", 128'(cnt), 128'(mc));
        if (mc != 0) chk(sel == 0 ? "a_deq_head" : "b_deq_head", 128'(head), 128'(sel == 0 ? qa[0] : qb[0]));
        ef = ev && (mc != dep);
        df = dr && (mc != 0);
        enq_fired = ef;
        @(posedge clk);
        #1;
        if (fl) begin
            if (sel == 0) begin qa.delete(); mc_a = 0; end else begin qb.delete(); mc_b = 0; end
        end else if (sel == 0) begin
            if (df) qa.delete(0);
            if (ef) qa.push_back(inb);
            mc_a = mc_a + int'(ef) - int'(df);
        end else begin
            if (df) qb.delete(0);
            if (ef) qb.push_back(inb);
            mc_b = mc_b + int'(ef) - int'(df);
        end
    endtask

    initial begin
        logic f;
        int sent, budget;
        reset = 1'b0;
        a_enq_valid = 0; a_deq_ready = 0; a_flush = 0; a_enq = '0;
        b_enq_valid = 0; b_deq_ready = 0; b_flush = 0; b_enq = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", 128'(a_enq_ready), 128'(1));
        chk("rst_a_valid", 128'(a_deq_valid), 128'(0));
        chk("rst_a_count", 128'(a_count), 128'(0));
        reset = 1'b1;
        #1;

        // Single request with fixed fields; visible one cycle later.
        a_enq_valid = 1;
        a_enq = '{addr: 40'h00_1234_5678, tag: 10'h2A, cmd: 5'h01, typ: 3'd3,
                  kill: 1'b0, phys: 1'b1, data: 64'hDEAD_BEEF_CAFE_F00D};
        tick(0, f);
        a_enq_valid = 0;
        chk("single_tag", 128'(a_deq.tag), 128'(10'h2A));
        chk("single_data", 128'(a_deq.data), 128'(64'hDEAD_BEEF_CAFE_F00D));
        tick(0, f);
        a_deq_ready = 1;
        tick(0, f);
        a_deq_ready = 0;

        // Fill DEPTH=2 with tags 1,2,3; tag 3 held until space, then drained in order.
        sent = 1; budget = 0;
        a_enq_valid = 1; a_enq = mk(10'd1);
        while (sent <= 3 && budget < 20) begin
            tick(0, f);
            budget++;
            if (f) begin
                sent++;
                a_enq = mk(10'(sent));
            end
            if (budget == 4) a_deq_ready = 1;
        end
        if (sent <= 3) chk("full_timeout", 128'(0), 128'(1));
        a_enq_valid = 0;
        budget = 0;
        while (mc_a != 0 && budget < 10) begin tick(0, f); budget++; end
        if (mc_a != 0) chk("drain_a_timeout", 128'(0), 128'(1));
        a_deq_ready = 0;

        // Steady stream at occupancy 1.
        a_enq_valid = 1; a_enq = mk(10'h100);
        tick(0, f);
        a_deq_ready = 1;
        for (int i = 0; i < 20; i++) begin
            a_enq = mk(10'(10'h101 + i));
            tick(0, f);
            chk("stream_count", 128'(a_count), 128'(1));
        end
        a_enq_valid = 0;
        tick(0, f);
        tick(0, f);
        a_deq_ready = 0;

        // DEPTH=3: ten requests against random dcache back-pressure.
        sent = 1; budget = 0;
        b_enq_valid = 1; b_enq = mk(10'd1);
        while (sent <= 10 && budget < 200) begin
            b_deq_ready = 1'($urandom_range(0, 1));
            tick(1, f);
            chk("b_count_le3", 128'(b_count <= 2'd3), 128'(1));
            budget++;
            if (f) begin
                sent++;
                b_enq = mk(10'(sent));
            end
        end
        if (sent <= 10) chk("rand_timeout", 128'(0), 128'(1));
        b_enq_valid = 0; b_deq_ready = 1;
        budget = 0;
        while (mc_b != 0 && budget < 10) begin tick(1, f); budget++; end
        if (mc_b != 0) chk("drain_b_timeout", 128'(0), 128'(1));
        b_deq_ready = 0;

        // Flush at count=2 together with an accepted enq of tag 7.
        b_enq_valid = 1;
        b_enq = mk(10'd5); tick(1, f);
        b_enq = mk(10'd6); tick(1, f);
        b_enq = mk(10'd7); b_flush = 1;
        tick(1, f);
        b_flush = 0; b_enq_valid = 0;
        chk("flush_count", 128'(b_count), 128'(0));
        chk("flush_valid", 128'(b_deq_valid), 128'(0));
        b_enq_valid = 1; b_enq = mk(10'd8);
        tick(1, f);
        b_enq_valid = 0;
        chk("post_flush_tag", 128'(b_deq.tag), 128'(10'd8));
        b_deq_ready = 1;
        tick(1, f);
        tick(1, f);
        b_deq_ready = 0;

        // Asynchronous reset mid-cycle with two entries held.
        a_enq_valid = 1;
        a_enq = mk(10'h31); tick(0, f);
        a_enq = mk(10'h32); tick(0, f);
        a_enq_valid = 0;
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 128'(a_deq_valid), 128'(0));
        chk("async_count", 128'(a_count), 128'(0));
        chk("async_ready", 128'(a_enq_ready), 128'(1));
        qa.delete(); mc_a = 0; qb.delete(); mc_b = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        a_enq_valid = 1; a_enq = mk(10'h55);
        tick(0, f);
        a_enq_valid = 0;
        chk("after_rst_tag", 128'(a_deq.tag), 128'(10'h55));
        a_deq_ready = 1;
        tick(0, f);
        tick(0, f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
